// File: rtl/link_pkg.sv
`default_nettype none
// ============================================================================
// Module   : link_pkg
// Brief    : Shared types and defaults for the Link game-level controller:
//            FSM state encoding, facing direction encoding, button and
//            command bundles, and small decode helpers.
// Revision : 1.0 - initial release
// ============================================================================
package link_pkg;

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_WAIT   = 3'd1,
        S_DECIDE = 3'd2,
        S_ATTACK = 3'd3,
        S_MOVE   = 3'd4,
        S_IDLE   = 3'd5,
        S_DRAW   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    localparam int c_MOVE_DIV        = 2;
    localparam int c_ATTACK_COOLDOWN = 8;

    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
        logic attack;
    } btn_t;

    typedef struct packed {
        logic init;
        logic idle;
        logic attack;
        logic up;
        logic down;
        logic left;
        logic right;
        logic draw;
    } cmd_t;

    // One-hot command word for a given state; movement uses the latched dir.
    function automatic cmd_t cmd_decode(input state_t s, input dir_t d);
        cmd_t c;
        c = '0;
        case (s)
            S_INIT:   c.init   = 1'b1;
            S_IDLE:   c.idle   = 1'b1;
            S_ATTACK: c.attack = 1'b1;
            S_DRAW:   c.draw   = 1'b1;
            S_MOVE: begin
                case (d)
                    DIR_UP:   c.up    = 1'b1;
                    DIR_DOWN: c.down  = 1'b1;
                    DIR_LEFT: c.left  = 1'b1;
                    default:  c.right = 1'b1;
                endcase
            end
            default:  c = '0;
        endcase
        return c;
    endfunction

    // Direction priority when several are held: up > down > left > right.
    function automatic dir_t dir_pick(input btn_t b);
        if (b.up)        return DIR_UP;
        else if (b.down) return DIR_DOWN;
        else if (b.left) return DIR_LEFT;
        else             return DIR_RIGHT;
    endfunction

endpackage
`default_nettype wire

// File: rtl/link_control_if.sv
`default_nettype none
// ============================================================================
// Module   : link_control_if
// Brief    : Command/handshake bundle between the Link controller (master)
//            and the datapath (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface link_control_if;

    logic init;
    logic idle;
    logic attack;
    logic up;
    logic down;
    logic left;
    logic right;
    logic draw;

    logic init_done;
    logic idle_done;
    logic attack_done;
    logic move_done;
    logic draw_done;

    modport master (
        output init, idle, attack, up, down, left, right, draw,
        input  init_done, idle_done, attack_done, move_done, draw_done
    );

    modport slave (
        input  init, idle, attack, up, down, left, right, draw,
        output init_done, idle_done, attack_done, move_done, draw_done
    );

endinterface
`default_nettype wire

// File: rtl/frame_pacer.sv
`default_nettype none
// ============================================================================
// Module   : frame_pacer
// Brief    : Frame-tick bookkeeping for the Link controller: pending-frame
//            flag, sticky overrun flag, and the saturating move/cooldown
//            frame counters stepped once per decision.
// Revision : 1.0 - initial release
// ============================================================================
module frame_pacer #(
    parameter int MOVE_DIV        = 2,
    parameter int ATTACK_COOLDOWN = 8,
    parameter int CNT_W           = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic i_frame_tick,
    input  logic i_clear_pending,
    input  logic i_decide,
    input  logic i_load_move,
    input  logic i_load_cool,
    input  logic i_wd_error,
    output logic o_tick_pending,
    output logic o_frame_overrun,
    output logic o_move_zero,
    output logic o_cool_zero
);

    localparam logic [CNT_W-1:0] c_MOVE_LOAD = CNT_W'(MOVE_DIV - 1);
    localparam logic [CNT_W-1:0] c_COOL_LOAD = CNT_W'(ATTACK_COOLDOWN - 1);

    logic             r_pending;
    logic             r_overrun;
    logic [CNT_W-1:0] r_move_cnt;
    logic [CNT_W-1:0] r_cool_cnt;

    // A tick always leaves a frame pending; a second tick before the first is consumed is an overrun.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_pending <= i_frame_tick | (r_pending & ~i_clear_pending);
            if ((i_frame_tick & r_pending & ~i_clear_pending) | i_wd_error)
                r_overrun <= 1'b1;
        end
    end

    // Counters step once per decision: reload on the chosen action, otherwise count down to zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_move_cnt <= '0;
            r_cool_cnt <= '0;
        end else if (i_decide) begin
            if (i_load_move)
                r_move_cnt <= c_MOVE_LOAD;
            else if (r_move_cnt != '0)
                r_move_cnt <= r_move_cnt - 1'b1;

            if (i_load_cool)
                r_cool_cnt <= c_COOL_LOAD;
            else if (r_cool_cnt != '0)
                r_cool_cnt <= r_cool_cnt - 1'b1;
        end
    end

    assign o_tick_pending  = r_pending;
    assign o_frame_overrun = r_overrun;
    assign o_move_zero     = (r_move_cnt == '0);
    assign o_cool_zero     = (r_cool_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/link_control.sv
`default_nettype none
// ============================================================================
// Module   : link_control
// Brief    : Game-level control FSM for Link. Paces play on the 60 Hz frame
//            tick, picks one action per frame from the buttons and drives
//            registered one-hot command strobes to the datapath.
// Optional : LINK_CTRL_WATCHDOG_EN - adds a per-state clock watchdog that
//            forces S_INIT and flags frame_overrun when a done never arrives.
// Revision : 1.0 - initial release
// ============================================================================
module link_control
    import link_pkg::*;
#(
    parameter int MOVE_DIV        = c_MOVE_DIV,
    parameter int ATTACK_COOLDOWN = c_ATTACK_COOLDOWN,
    parameter int CNT_W           = 4,
    parameter int TIMEOUT_CYCLES  = 1000000
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           frame_tick,
    input  logic           btn_up,
    input  logic           btn_down,
    input  logic           btn_left,
    input  logic           btn_right,
    input  logic           btn_attack,
    link_control_if.master dp,
    output logic [1:0]     facing,
    output logic           frame_overrun
);

    if (MOVE_DIV < 1 || ATTACK_COOLDOWN < 1 || TIMEOUT_CYCLES < 2 ||
        MOVE_DIV > (1 << CNT_W) || ATTACK_COOLDOWN > (1 << CNT_W)) begin : g_param_check
        $error("link_control: parameter out of range");
    end

    state_t r_state;
    dir_t   r_dir;
    cmd_t   r_cmd;
    btn_t   r_btn_q;

    state_t w_state_next;
    dir_t   w_dir_next;
    logic   w_clear_pending;
    logic   w_load_move;
    logic   w_load_cool;
    logic   w_tick_pending;
    logic   w_move_zero;
    logic   w_cool_zero;
    logic   w_any_dir;
    logic   w_wd_fire;

    assign w_any_dir = r_btn_q.up | r_btn_q.down | r_btn_q.left | r_btn_q.right;

`ifdef LINK_CTRL_WATCHDOG_EN
    localparam int c_WD_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT_CYCLES - 1);

    logic [c_WD_W-1:0] r_wd_cnt;
    logic              w_busy;

    assign w_busy = (r_state != S_WAIT) && (r_state != S_DECIDE);

    // Clocks spent in the current waiting-for-done state; restarts on every state change.
    always_ff @(posedge clock) begin
        if (reset || w_wd_fire || !w_busy || (w_state_next != r_state))
            r_wd_cnt <= '0;
        else
            r_wd_cnt <= r_wd_cnt + 1'b1;
    end
`endif

    // Next-state selection; done inputs only count in their own state.
    always_comb begin
        w_state_next    = r_state;
        w_dir_next      = r_dir;
        w_clear_pending = 1'b0;
        w_load_move     = 1'b0;
        w_load_cool     = 1'b0;
        case (r_state)
            // init must have been visible for a cycle before its done is honoured
            S_INIT:   if (dp.init_done && r_cmd.init) w_state_next = S_DRAW;
            S_WAIT: begin
                if (w_tick_pending) begin
                    w_clear_pending = 1'b1;
                    w_state_next    = S_DECIDE;
                end
            end
            S_DECIDE: begin
                if (r_btn_q.attack && w_cool_zero) begin
                    w_state_next = S_ATTACK;
                    w_load_cool  = 1'b1;
                end else if (w_any_dir && w_move_zero) begin
                    w_state_next = S_MOVE;
                    w_load_move  = 1'b1;
                    w_dir_next   = dir_pick(r_btn_q);
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_ATTACK: if (dp.attack_done) w_state_next = S_DRAW;
            S_MOVE:   if (dp.move_done)   w_state_next = S_DRAW;
            S_IDLE:   if (dp.idle_done)   w_state_next = S_DRAW;
            S_DRAW:   if (dp.draw_done)   w_state_next = S_WAIT;
            default:  w_state_next = S_INIT;
        endcase
`ifdef LINK_CTRL_WATCHDOG_EN
        w_wd_fire = w_busy && (r_wd_cnt == c_WD_LAST) && (w_state_next == r_state);
`else
        w_wd_fire = 1'b0;
`endif
        if (w_wd_fire)
            w_state_next = S_INIT;
    end

    // State register with commands registered from the state being entered.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_INIT;
            r_dir   <= DIR_DOWN;
            r_cmd   <= '0;
        end else begin
            r_state <= w_state_next;
            r_dir   <= w_dir_next;
            r_cmd   <= cmd_decode(w_state_next, w_dir_next);
        end
    end

    // Buttons are sampled once per frame, as the pending frame is consumed.
    always_ff @(posedge clock) begin
        if (reset)
            r_btn_q <= '0;
        else if (w_clear_pending)
            r_btn_q <= {btn_up, btn_down, btn_left, btn_right, btn_attack};
    end

    frame_pacer #(
        .MOVE_DIV        (MOVE_DIV),
        .ATTACK_COOLDOWN (ATTACK_COOLDOWN),
        .CNT_W           (CNT_W)
    ) u_frame_pacer (
        .clock           (clock),
        .reset           (reset),
        .i_frame_tick    (frame_tick),
        .i_clear_pending (w_clear_pending),
        .i_decide        (r_state == S_DECIDE),
        .i_load_move     (w_load_move),
        .i_load_cool     (w_load_cool),
        .i_wd_error      (w_wd_fire),
        .o_tick_pending  (w_tick_pending),
        .o_frame_overrun (frame_overrun),
        .o_move_zero     (w_move_zero),
        .o_cool_zero     (w_cool_zero)
    );

    assign dp.init   = r_cmd.init;
    assign dp.idle   = r_cmd.idle;
    assign dp.attack = r_cmd.attack;
    assign dp.up     = r_cmd.up;
    assign dp.down   = r_cmd.down;
    assign dp.left   = r_cmd.left;
    assign dp.right  = r_cmd.right;
    assign dp.draw   = r_cmd.draw;
    assign facing    = r_dir;

endmodule
`default_nettype wire

// File: tb/tb_link_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_link_control
// Brief    : Self-checking bench for link_control: a fixed frame table, then
//            random button frames against a frame-level reference model,
//            plus overrun, mid-operation reset and watchdog sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_link_control;

    localparam int c_MOVE_DIV = 2;
    localparam int c_COOL     = 8;
    localparam int c_TIMEOUT  = 50;

    localparam int A_IDLE  = 0;
    localparam int A_ATK   = 1;
    localparam int A_UP    = 2;
    localparam int A_DOWN  = 3;
    localparam int A_LEFT  = 4;
    localparam int A_RIGHT = 5;
    localparam int A_INIT  = 6;
    localparam int A_DRAW  = 7;
    localparam int A_NONE  = 8;

    // button vector order: {up, down, left, right, attack}
    localparam logic [4:0] B_NONE = 5'b00000;
    localparam logic [4:0] B_R    = 5'b00010;
    localparam logic [4:0] B_UDA  = 5'b11001;
    localparam logic [4:0] B_L    = 5'b00100;
    localparam logic [4:0] B_DR   = 5'b01010;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic       btn_attack = 1'b0;
    logic [1:0] facing;
    logic       frame_overrun;

    always #5 clock = ~clock;

    link_control_if dp();

    link_control #(
        .MOVE_DIV        (c_MOVE_DIV),
        .ATTACK_COOLDOWN (c_COOL),
        .CNT_W           (4),
        .TIMEOUT_CYCLES  (c_TIMEOUT)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .frame_tick    (frame_tick),
        .btn_up        (btn_up),
        .btn_down      (btn_down),
        .btn_left      (btn_left),
        .btn_right     (btn_right),
        .btn_attack    (btn_attack),
        .dp            (dp),
        .facing        (facing),
        .frame_overrun (frame_overrun)
    );

    typedef struct {
        logic [4:0] btn;
        int         act;
        int         face;
    } vec_t;

    vec_t       tbl [18];
    int         errors = 0;
    int         checks = 0;
    int         m_move, m_cool, m_facing, m_act;
    logic [4:0] r_b;
`ifdef LINK_CTRL_WATCHDOG_EN
    int         wd_n;
`endif

    function automatic int active_cmds();
        return $countones({dp.init, dp.idle, dp.attack, dp.up, dp.down,
                           dp.left, dp.right, dp.draw});
    endfunction

    function automatic int cmd_code();
        if (dp.init)   return A_INIT;
        if (dp.idle)   return A_IDLE;
        if (dp.attack) return A_ATK;
        if (dp.up)     return A_UP;
        if (dp.down)   return A_DOWN;
        if (dp.left)   return A_LEFT;
        if (dp.right)  return A_RIGHT;
        if (dp.draw)   return A_DRAW;
        return A_NONE;
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Frame-level reference: one action per frame from the held buttons.
    task automatic model_frame(input logic [4:0] b, output int act);
        if (b[0] && m_cool == 0) begin
            act    = A_ATK;
            m_cool = c_COOL - 1;
            if (m_move > 0) m_move--;
        end else if (b[4:1] != 4'd0 && m_move == 0) begin
            if (b[4])      act = A_UP;
            else if (b[3]) act = A_DOWN;
            else if (b[2]) act = A_LEFT;
            else           act = A_RIGHT;
            m_move   = c_MOVE_DIV - 1;
            m_facing = act - A_UP;
            if (m_cool > 0) m_cool--;
        end else begin
            act = A_IDLE;
            if (m_move > 0) m_move--;
            if (m_cool > 0) m_cool--;
        end
    endtask

    task automatic clear_dones();
        dp.init_done   = 1'b0;
        dp.idle_done   = 1'b0;
        dp.attack_done = 1'b0;
        dp.move_done   = 1'b0;
        dp.draw_done   = 1'b0;
    endtask

    task automatic do_reset_init();
        reset = 1'b1;
        frame_tick = 1'b0;
        clear_dones();
        repeat (3) step();
        check("rst cmds", active_cmds(), 0);
        check("rst facing", int'(facing), 1);
        check("rst overrun", int'(frame_overrun), 0);
        dp.init_done = 1'b1;
        reset = 1'b0;
        step();
        check("init high", cmd_code(), A_INIT);
        step();
        check("init to draw", cmd_code(), A_DRAW);
        dp.init_done = 1'b0;
        dp.draw_done = 1'b1;
        step();
        dp.draw_done = 1'b0;
        check("init wait idle", active_cmds(), 0);
        m_move = 0;
        m_cool = 0;
        m_facing = 1;
    endtask

    // Tick, then expect the command exactly three clocks later.
    task automatic start_frame(input logic [4:0] b, input int exp_act, input int exp_face,
                               input string tag);
        {btn_up, btn_down, btn_left, btn_right, btn_attack} = b;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        check({tag, " lat1"}, active_cmds(), 0);
        step();
        check({tag, " lat2"}, active_cmds(), 0);
        step();
        check({tag, " onehot"}, active_cmds(), 1);
        check({tag, " cmd"}, cmd_code(), exp_act);
        check({tag, " facing"}, int'(facing), exp_face);
    endtask

    // Probe with non-matching dones, return the real done, then the draw handshake.
    task automatic finish_frame(input int dly, input bit hold_draw, input string tag);
        int code;
        code = cmd_code();
        dp.init_done   = 1'b1;
        dp.draw_done   = 1'b1;
        dp.idle_done   = (code != A_IDLE);
        dp.attack_done = (code != A_ATK);
        dp.move_done   = !(code inside {[A_UP:A_RIGHT]});
        step();
        clear_dones();
        check({tag, " ignore"}, cmd_code(), code);
        repeat (dly) step();
        case (code)
            A_IDLE:  dp.idle_done = 1'b1;
            A_ATK:   dp.attack_done = 1'b1;
            default: dp.move_done = 1'b1;
        endcase
        step();
        clear_dones();
        check({tag, " draw"}, cmd_code(), A_DRAW);
        if (!hold_draw) begin
            dp.draw_done = 1'b1;
            step();
            dp.draw_done = 1'b0;
            check({tag, " wait"}, active_cmds(), 0);
        end
    endtask

    initial begin
        tbl[0]  = '{B_R,   A_RIGHT, 3};
        tbl[1]  = '{B_R,   A_IDLE,  3};
        tbl[2]  = '{B_R,   A_RIGHT, 3};
        tbl[3]  = '{B_R,   A_IDLE,  3};
        tbl[4]  = '{B_R,   A_RIGHT, 3};
        tbl[5]  = '{B_UDA, A_ATK,   3};
        tbl[6]  = '{B_UDA, A_UP,    0};
        tbl[7]  = '{B_UDA, A_IDLE,  0};
        tbl[8]  = '{B_UDA, A_UP,    0};
        tbl[9]  = '{B_UDA, A_IDLE,  0};
        tbl[10] = '{B_UDA, A_UP,    0};
        tbl[11] = '{B_UDA, A_IDLE,  0};
        tbl[12] = '{B_UDA, A_UP,    0};
        tbl[13] = '{B_UDA, A_ATK,   0};
        tbl[14] = '{B_NONE, A_IDLE, 0};
        tbl[15] = '{B_L,   A_LEFT,  2};
        tbl[16] = '{B_DR,  A_IDLE,  2};
        tbl[17] = '{B_DR,  A_DOWN,  1};

        clear_dones();
        do_reset_init();

        for (int i = 0; i < 18; i++) begin
            model_frame(tbl[i].btn, m_act);
            start_frame(tbl[i].btn, tbl[i].act, tbl[i].face, $sformatf("tbl%0d", i));
            finish_frame(2, 1'b0, $sformatf("tbl%0d", i));
        end

        for (int i = 0; i < 40; i++) begin
            r_b = 5'($urandom_range(0, 31));
            model_frame(r_b, m_act);
            start_frame(r_b, m_act, m_facing, $sformatf("rnd%0d", i));
            finish_frame(int'($urandom_range(0, 3)), 1'b0, $sformatf("rnd%0d", i));
            repeat ($urandom_range(0, 3)) step();
        end

        // two ticks while draw is withheld: overrun, but only one frame queued
        model_frame(B_NONE, m_act);
        start_frame(B_NONE, m_act, m_facing, "ovr");
        finish_frame(1, 1'b1, "ovr");
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        check("ovr first tick", int'(frame_overrun), 0);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        check("ovr set", int'(frame_overrun), 1);
        repeat (5) step();
        check("ovr draw held", cmd_code(), A_DRAW);
        check("ovr sticky", int'(frame_overrun), 1);
        dp.draw_done = 1'b1;
        step();
        dp.draw_done = 1'b0;
        check("ovr wait", active_cmds(), 0);
        step();
        check("ovr decide", active_cmds(), 0);
        model_frame(B_NONE, m_act);
        step();
        check("ovr extra cmd", cmd_code(), m_act);
        finish_frame(1, 1'b0, "ovrx");
        repeat (20) step();
        check("ovr single frame", active_cmds(), 0);
        check("ovr still set", int'(frame_overrun), 1);

        // reset while a move is outstanding
        do_reset_init();
        start_frame(B_R, A_RIGHT, 3, "mid");
        reset = 1'b1;
        step();
        check("mid rst cmds", active_cmds(), 0);
        reset = 1'b0;
        step();
        check("mid rst init", cmd_code(), A_INIT);

`ifdef LINK_CTRL_WATCHDOG_EN
        do_reset_init();
        start_frame(B_NONE, A_IDLE, 1, "wd");
        wd_n = 0;
        for (int k = 0; k < 80 && dp.idle; k++) begin
            wd_n++;
            step();
        end
        check("wd idle cycles", wd_n, c_TIMEOUT);
        check("wd init", cmd_code(), A_INIT);
        check("wd overrun", int'(frame_overrun), 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
